// File: rtl/ram_copy_engine.sv
// ram_copy_engine: byte-at-a-time copy between two address ranges of a 16x8 RAM over its
// read/write ready handshake. Every wait state is supervised by a TIMEOUT-cycle watchdog.
// Define RAM_COPY_CHECKSUM_EN to add an XOR checksum of all bytes read during a copy.
module ram_copy_engine #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       Start,
    input  logic [3:0] SrcAddr,
    input  logic [3:0] DstAddr,
    input  logic [4:0] Length,
    output logic       Busy,
    output logic       Done,
    output logic       Error,
`ifdef RAM_COPY_CHECKSUM_EN
    output logic [7:0] Checksum,
`endif
    output logic       Read,
    output logic [3:0] ReadAddr,
    input  logic [7:0] ReadData,
    input  logic       ReadReady,
    output logic       Write,
    output logic [3:0] WriteAddr,
    output logic [7:0] WriteData,
    input  logic       WriteReady
);

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StWrReq,
        StWrWait,
        StDone
    } state_t;

    // Abort fires at the end of the TIMEOUT-th wait cycle without ready.
    localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

    state_t     state;
    logic [3:0] src;
    logic [3:0] dst;
    logic [4:0] count;
    logic [7:0] wait_cnt;
    logic [7:0] buffer;

    // The byte buffer drives the write data bus directly.
    assign WriteData = buffer;

    // Copy sequencer; all strobes and status outputs are registered here.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= StIdle;
            src       <= 4'd0;
            dst       <= 4'd0;
            count     <= 5'd0;
            wait_cnt  <= 8'd0;
            buffer    <= 8'd0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Error     <= 1'b0;
            Read      <= 1'b0;
            ReadAddr  <= 4'd0;
            Write     <= 1'b0;
            WriteAddr <= 4'd0;
`ifdef RAM_COPY_CHECKSUM_EN
            Checksum  <= 8'd0;
`endif
        end else begin
            // Strobes and Done are single-cycle unless re-asserted below.
            Read  <= 1'b0;
            Write <= 1'b0;
            Done  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (Start) begin
                        src   <= SrcAddr;
                        dst   <= DstAddr;
                        count <= (Length > 5'd16) ? 5'd16 : Length;
                        Error <= 1'b0;
                        Busy  <= 1'b1;
`ifdef RAM_COPY_CHECKSUM_EN
                        Checksum <= 8'd0;
`endif
                        if (Length == 5'd0) begin
                            Done  <= 1'b1;
                            state <= StDone;
                        end else begin
                            Read     <= 1'b1;
                            ReadAddr <= SrcAddr;
                            state    <= StRdReq;
                        end
                    end
                end
                StRdReq: begin
                    wait_cnt <= 8'd0;
                    state    <= StRdWait;
                end
                StRdWait: begin
                    if (ReadReady) begin
                        buffer    <= ReadData;
                        Write     <= 1'b1;
                        WriteAddr <= dst;
`ifdef RAM_COPY_CHECKSUM_EN
                        Checksum  <= Checksum ^ ReadData;
`endif
                        state     <= StWrReq;
                    end else if (wait_cnt == WaitLast) begin
                        Error <= 1'b1;
                        Done  <= 1'b1;
                        state <= StDone;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                StWrReq: begin
                    wait_cnt <= 8'd0;
                    state    <= StWrWait;
                end
                StWrWait: begin
                    if (WriteReady) begin
                        src   <= src + 4'd1;
                        dst   <= dst + 4'd1;
                        count <= count - 5'd1;
                        if (count == 5'd1) begin
                            Done  <= 1'b1;
                            state <= StDone;
                        end else begin
                            Read     <= 1'b1;
                            ReadAddr <= src + 4'd1;
                            state    <= StRdReq;
                        end
                    end else if (wait_cnt == WaitLast) begin
                        Error <= 1'b1;
                        Done  <= 1'b1;
                        state <= StDone;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                StDone: begin
                    Busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_copy_engine.sv
// tb_ram_copy_engine: directed bench with a behavioural 16x8 RAM responder that raises ready
// in the second cycle after each strobe (optionally never, for write-side timeout).
module tb_ram_copy_engine;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       Start = 1'b0;
    logic [3:0] SrcAddr = 4'd0;
    logic [3:0] DstAddr = 4'd0;
    logic [4:0] Length = 5'd0;
    logic       Busy, Done, Error;
    logic       Read, Write;
    logic [3:0] ReadAddr, WriteAddr;
    logic [7:0] ReadData = 8'd0;
    logic [7:0] WriteData;
    logic       ReadReady = 1'b0;
    logic       WriteReady = 1'b0;
`ifdef RAM_COPY_CHECKSUM_EN
    logic [7:0] Checksum;
`endif

    ram_copy_engine #(.TIMEOUT(15)) dut (
        .clock     (clock),
        .reset     (reset),
        .Start     (Start),
        .SrcAddr   (SrcAddr),
        .DstAddr   (DstAddr),
        .Length    (Length),
        .Busy      (Busy),
        .Done      (Done),
        .Error     (Error),
`ifdef RAM_COPY_CHECKSUM_EN
        .Checksum  (Checksum),
`endif
        .Read      (Read),
        .ReadAddr  (ReadAddr),
        .ReadData  (ReadData),
        .ReadReady (ReadReady),
        .Write     (Write),
        .WriteAddr (WriteAddr),
        .WriteData (WriteData),
        .WriteReady(WriteReady)
    );

    always #5 clock = ~clock;

    logic [7:0] mem [16];
    logic [3:0] rd_log[$];
    logic [3:0] rd_addr = 4'd0;
    int         rd_ph = 0;
    int         wr_ph = 0;
    int         n_reads = 0;
    int         n_writes = 0;
    int         n_both = 0;
    logic       stall_wr = 1'b0;

    int n_checks = 0;
    int n_pass = 0;

    // RAM responder and strobe monitor, sampling mid-cycle.
    always @(negedge clock) begin
        if (reset) begin
            rd_ph      = 0;
            wr_ph      = 0;
            ReadReady  = 1'b0;
            WriteReady = 1'b0;
        end else begin
            if (Read && Write) n_both++;
            ReadReady  = 1'b0;
            WriteReady = 1'b0;
            if (Read) begin
                n_reads++;
                rd_addr = ReadAddr;
                rd_log.push_back(ReadAddr);
                rd_ph = 1;
            end else if (rd_ph == 1) begin
                rd_ph = 2;
            end else if (rd_ph == 2) begin
                ReadReady = 1'b1;
                ReadData  = mem[rd_addr];
                rd_ph     = 0;
            end
            if (Write) begin
                n_writes++;
                mem[WriteAddr] = WriteData;
                wr_ph = 1;
            end else if (wr_ph == 1) begin
                wr_ph = 2;
            end else if (wr_ph == 2) begin
                if (!stall_wr) WriteReady = 1'b1;
                wr_ph = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic preload();
        for (int i = 0; i < 16; i++) mem[i] = 8'(8'h10 + i);
    endtask

    // Pulses Start for one edge; returns at the negedge right after the sampling edge.
    task automatic do_start(input logic [3:0] s, input logic [3:0] d, input logic [4:0] l,
                            output int rd0, output int wr0);
        rd0 = n_reads;
        wr0 = n_writes;
        @(negedge clock);
        SrcAddr = s;
        DstAddr = d;
        Length  = l;
        Start   = 1'b1;
        @(negedge clock);
        Start = 1'b0;
    endtask

    // Scans negedges starting at index k0 for Done; 'at' is cycles after the Start edge.
    task automatic wait_done(input string tag, input int k0, output int at);
        int k;
        logic seen;
        k    = k0;
        at   = -1;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (Done) begin
                at   = k;
                seen = 1'b1;
                break;
            end
            @(negedge clock);
            k++;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        int rd0, wr0, at, ok;
        preload();

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_error", 32'(Error), 32'd0);
        check("rst_strobes", {30'd0, Read, Write}, 32'd0);
        check("rst_addr_data", {16'd0, ReadAddr, WriteAddr, WriteData}, 32'd0);
`ifdef RAM_COPY_CHECKSUM_EN
        check("rst_checksum", 32'(Checksum), 32'd0);
`endif
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // 4-byte copy 0->8, with an ignored Start while busy
        do_start(4'd0, 4'd8, 5'd4, rd0, wr0);
        check("c4_busy_e0", 32'(Busy), 32'd1);
        check("c4_read_e0", {27'd0, Read, ReadAddr}, {27'd0, 1'b1, 4'd0});
        @(negedge clock);
        SrcAddr = 4'd5; DstAddr = 4'd0; Length = 5'd1; Start = 1'b1;
        @(negedge clock);
        Start = 1'b0;
        wait_done("c4", 2, at);
        check("c4_done_cycle", 32'(at), 32'd24);
        check("c4_error", 32'(Error), 32'd0);
`ifdef RAM_COPY_CHECKSUM_EN
        check("c4_checksum", 32'(Checksum), 32'h00);
`endif
        @(negedge clock);
        check("c4_busy_fall", {30'd0, Busy, Done}, 32'd0);
        repeat (4) @(negedge clock);
        check("c4_bytes", {mem[8], mem[9], mem[10], mem[11]}, 32'h10111213);
        check("c4_untouched", {mem[0], mem[12]}, 32'h101C);
        check("c4_nreads", 32'(n_reads - rd0), 32'd4);
        check("c4_nwrites", 32'(n_writes - wr0), 32'd4);

        // 3-byte copy with source wrap 14->3
        preload();
        rd_log.delete();
        do_start(4'd14, 4'd3, 5'd3, rd0, wr0);
        wait_done("wrap", 0, at);
        check("wrap_done_cycle", 32'(at), 32'd18);
        repeat (3) @(negedge clock);
        check("wrap_bytes", {8'd0, mem[3], mem[4], mem[5]}, 32'h001E1F10);
        check("wrap_nreads", 32'(rd_log.size()), 32'd3);
        if (rd_log.size() == 3)
            check("wrap_rd_addrs", {20'd0, rd_log[0], rd_log[1], rd_log[2]}, 32'h00000EF0);

        // Length 0
        do_start(4'd2, 4'd9, 5'd0, rd0, wr0);
        wait_done("len0", 0, at);
        check("len0_done_cycle", 32'(at), 32'd0);
        @(negedge clock);
        check("len0_busy_fall", 32'(Busy), 32'd0);
        repeat (3) @(negedge clock);
        check("len0_strobes", 32'((n_reads - rd0) + (n_writes - wr0)), 32'd0);

        // Length 20 clamps to 16; overlapping 0->1 smears byte 0 across the RAM
        preload();
        do_start(4'd0, 4'd1, 5'd20, rd0, wr0);
        wait_done("len20", 0, at);
        check("len20_done_cycle", 32'(at), 32'd96);
`ifdef RAM_COPY_CHECKSUM_EN
        check("len20_checksum", 32'(Checksum), 32'h00);
`endif
        repeat (3) @(negedge clock);
        check("len20_nwrites", 32'(n_writes - wr0), 32'd16);
        ok = 0;
        for (int i = 0; i < 16; i++) if (mem[i] == 8'h10) ok++;
        check("len20_overlap_bytes", 32'(ok), 32'd16);

        // Write-side timeout
        preload();
        stall_wr = 1'b1;
        do_start(4'd0, 4'd8, 5'd4, rd0, wr0);
        wait_done("tmo", 0, at);
        check("tmo_done_cycle", 32'(at), 32'd19);
        check("tmo_error", 32'(Error), 32'd1);
`ifdef RAM_COPY_CHECKSUM_EN
        check("tmo_checksum", 32'(Checksum), 32'h10);
`endif
        repeat (10) @(negedge clock);
        check("tmo_error_sticky", {30'd0, Error, Busy}, 32'd2);
        check("tmo_nreads", 32'(n_reads - rd0), 32'd1);
        stall_wr = 1'b0;
        do_start(4'd0, 4'd0, 5'd0, rd0, wr0);
        check("tmo_error_clear", 32'(Error), 32'd0);
        repeat (3) @(negedge clock);

        // Reset during byte 2 of a 4-byte copy
        preload();
        do_start(4'd0, 4'd8, 5'd4, rd0, wr0);
        repeat (8) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_status", {29'd0, Busy, Done, Error}, 32'd0);
        check("mid_rst_strobes", {30'd0, Read, Write}, 32'd0);
        check("mid_rst_addr_data", {16'd0, ReadAddr, WriteAddr, WriteData}, 32'd0);
        rd0 = n_reads;
        wr0 = n_writes;
        @(negedge clock);
        @(posedge clock);
        #2 reset = 1'b0;
        repeat (20) @(negedge clock);
        check("mid_rst_quiet", 32'((n_reads - rd0) + (n_writes - wr0)), 32'd0);
        check("mid_rst_bytes", {mem[8], mem[9], mem[10], mem[11]}, 32'h10191A1B);

        check("never_rd_and_wr", 32'(n_both), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_copy_engine.md
# ram_copy_engine

Initiator-side controller for the 16×8 single-clock RAM block's read/write handshake. On a start command it copies 1–16 bytes from a source address range to a destination address range within the same RAM, one byte at a time. It sits between a command source (sequencer or test host) and the RAM's read/write port pair. It also supervises the responder's ready handshake with a timeout.

## Interface
Parameters:
- TIMEOUT, 15: maximum cycles spent in any wait state before abort (1..255).

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- Start  in  1  command strobe, sampled only in IDLE
- SrcAddr  in  4  first source byte address
- DstAddr  in  4  first destination byte address
- Length  in  5  byte count 0..16; values >16 treated as 16
- Busy  out  1  high from the cycle after accepted Start until DONE exits
- Done  out  1  one-cycle completion pulse
- Error  out  1  timeout flag; sticky until next accepted Start
- Read  out  1  RAM read strobe
- ReadAddr  out  4  RAM read address
- ReadData  in  8  RAM read data
- ReadReady  in  1  RAM read-ready
- Write  out  1  RAM write strobe
- WriteAddr  out  4  RAM write address
- WriteData  out  8  RAM write data
- WriteReady  in  1  RAM write-ready

## Operation
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE.
- IDLE: when Start=1, latch SrcAddr, DstAddr and min(Length,16) into internal registers. Clear Error. Go to RD_REQ, or to DONE if the length is 0. Start is ignored in all other states.
- RD_REQ: Read=1 and ReadAddr=src for exactly one cycle, then go to RD_WAIT.
- RD_WAIT: Read=0. When ReadReady=1, capture ReadData into the byte buffer and go to WR_REQ.
- WR_REQ: Write=1, WriteAddr=dst, WriteData=buffer for exactly one cycle, then go to WR_WAIT.
- WR_WAIT: Write=0. When WriteReady=1:
  - increment src and dst modulo 16 (15 wraps to 0);
  - decrement the remaining count;
  - go to RD_REQ if the count is nonzero, else to DONE.
- DONE: Done=1 for one cycle, then go to IDLE.
- Read and Write are never high in the same cycle. Each is high only in its REQ state.
- Copy order is ascending. Overlapping ranges are not special-cased: a byte already overwritten is read back as its new value.
- Timeout: a wait counter clears on entry to RD_WAIT or WR_WAIT. If it reaches TIMEOUT without ready, set Error=1 and go to DONE (abort). Remaining bytes are not copied.

## Timing
- Reset values: Busy=0, Done=0, Error=0, Read=0, Write=0, ReadAddr=0, WriteAddr=0, WriteData=0; state is IDLE and all counters are 0.
- Reset mid-copy: everything above is restored immediately and no further strobes are issued. RAM contents stay partially copied.
- Start sampled at edge E0: Read=1 during cycle E0..E1 and Busy=1 from E0.
- With an ideal responder (ready low one cycle after each strobe, then high), each byte takes 6 cycles: RD_REQ 1, RD_WAIT 2, WR_REQ 1, WR_WAIT 2.
- Length N≥1: Done is high during the cycle starting at edge E0+6N, and Busy falls at E0+6N+1.
- Length 0: Done is high during cycle E0..E1, with no Read or Write.
- ReadData is captured on the edge that ends the first RD_WAIT cycle with ReadReady=1.
- Ready is not examined in the REQ cycle itself.

## Configuration
- RAM_COPY_CHECKSUM_EN defined:
  - adds output Checksum [7:0], with reset value 0;
  - Checksum is cleared on accepted Start;
  - each captured byte is XORed into Checksum;
  - Checksum is stable and valid while Done=1.
- RAM_COPY_CHECKSUM_EN undefined: the Checksum port and its logic are absent; all other behaviour is identical.

## Test plan
- RAM preloaded with 0x10..0x1F at 0..15; SrcAddr=0, DstAddr=8, Length=4 -> bytes 8..11 = 0x10..0x13; Done at E0+24; Error=0; Checksum=0x00 if enabled.
- SrcAddr=14, DstAddr=3, Length=3 -> reads at 14, 15, 0 (wrap); bytes 3..5 = 0x1E, 0x1F, 0x10.
- Length=0 -> Done one cycle after Start, no strobes. Length=20 -> exactly 16 byte copies.
- Responder holds WriteReady=0 permanently, TIMEOUT=15 -> Error=1, Done pulses after 15 WR_WAIT cycles, no further Read; Error clears on the next Start.
- Reset asserted during byte 2 of a 4-byte copy -> all outputs at reset values on the same edge; byte 1 copied, bytes 3..4 untouched. A Start pulse while Busy=1 is ignored.
